// File: rtl/calc_pkg.sv
// Shared encodings for the calculator datapath: controller commands, operations,
// display sources and the iterative-unit state.
package calc_pkg;

    localparam logic [2:0] OP_NOOP     = 3'b000;
    localparam logic [2:0] OP_DISP_A   = 3'b010;
    localparam logic [2:0] OP_DISP_B   = 3'b100;
    localparam logic [2:0] OP_COMPUTE  = 3'b101;
    localparam logic [2:0] OP_DISP_RES = 3'b110;
    localparam logic [2:0] OP_CLEAR    = 3'b111;

    localparam logic [1:0] CALC_ADD = 2'b00;
    localparam logic [1:0] CALC_SUB = 2'b01;
    localparam logic [1:0] CALC_MUL = 2'b10;
    localparam logic [1:0] CALC_DIV = 2'b11;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_RES  = 2'b11;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_RUN  = 1'b1
    } calc_state_t;

endpackage

// File: rtl/calc_iter_unit.sv
// N-step shift-add multiplier and restoring divider sharing one counter and FSM.
// done is high during the final running cycle; product/{rem,quo} are valid with it.
module calc_iter_unit
    import calc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          is_div,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          run_div,
    output logic [2*N-1:0] product,
    output logic [N-1:0]  rem,
    output logic [N-1:0]  quo,
    output calc_state_t   state
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   rem_q;
    logic [N-1:0]   quo_q;
    logic [N-1:0]   divisor;

    logic [2*N-1:0] acc_nxt;
    logic [N:0]     shifted;
    logic [N:0]     trial;
    logic           take;
    logic [N-1:0]   rem_nxt;
    logic [N-1:0]   quo_nxt;
    logic           last_step;

    assign acc_nxt   = mplier[0] ? acc + mcand : acc;
    // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
    assign shifted   = {rem_q, quo_q[N-1]};
    assign trial     = shifted - {1'b0, divisor};
    assign take      = shifted >= {1'b0, divisor};
    assign rem_nxt   = take ? trial[N-1:0] : shifted[N-1:0];
    assign quo_nxt   = {quo_q[N-2:0], take};
    assign last_step = (state == C_RUN) && (cnt == CW'(N - 1));

    assign busy    = (state == C_RUN);
    assign done    = last_step && !abort;
    assign product = acc_nxt;
    assign rem     = rem_nxt;
    assign quo     = quo_nxt;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state   <= C_IDLE;
            cnt     <= '0;
            run_div <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            divisor <= '0;
        end else begin
            case (state)
                C_IDLE: begin
                    if (start) begin
                        state   <= C_RUN;
                        cnt     <= '0;
                        run_div <= is_div;
                        acc     <= '0;
                        mcand   <= {{N{1'b0}}, a};
                        mplier  <= b;
                        rem_q   <= '0;
                        quo_q   <= a;
                        divisor <= b;
                    end
                end
                C_RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    rem_q  <= rem_nxt;
                    quo_q  <= quo_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_step) state <= C_IDLE;
                end
                default: state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/calc_datapath.sv
// Calculator execution datapath: operand capture, single-cycle add/sub, iterative mul/div
// and the sticky display register driven by the controller's op_code commands.
module calc_datapath
    import calc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     op_code,
    input  logic           wrt_addr,
    input  logic [1:0]     compute_op,
    input  logic [N-1:0]   data_in,
    output logic [2*N-1:0] disp_val,
    output logic [1:0]     disp_sel,
    output logic           busy,
    output logic           done,
    output logic           neg,
    output logic           div_zero
);

    // Command protocol: a command acts once when op_code changes (entry); holding it only
    // refreshes the display. done pulses for one cycle on every result write; no handshake back.
    logic [2:0]     prev_op;
    logic [N-1:0]   reg_a;
    logic [N-1:0]   reg_b;
    logic [2*N-1:0] result;

    logic           entry;
    logic           clear;
    logic           compute_entry;
    logic           start_iter;
    logic [N-1:0]   abs_diff;

    logic           iter_busy;
    logic           iter_done;
    logic           iter_div;
    logic [2*N-1:0] iter_product;
    logic [N-1:0]   iter_rem;
    logic [N-1:0]   iter_quo;
    calc_state_t    iter_state;

    // The previewed register is already implied by op_code, so wrt_addr carries no extra information.
    logic           unused_wrt_addr;
    assign unused_wrt_addr = wrt_addr;

    assign entry         = (op_code != prev_op);
    assign clear         = (op_code == OP_CLEAR);
    assign compute_entry = entry && (op_code == OP_COMPUTE) && (iter_state == C_IDLE);
    assign start_iter    = compute_entry &&
                           ((compute_op == CALC_MUL) || ((compute_op == CALC_DIV) && (reg_b != '0)));
    assign abs_diff      = (reg_a >= reg_b) ? reg_a - reg_b : reg_b - reg_a;
    assign busy          = iter_busy;

    calc_iter_unit #(.N(N)) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (start_iter),
        .is_div  (compute_op == CALC_DIV),
        .a       (reg_a),
        .b       (reg_b),
        .abort   (clear),
        .busy    (iter_busy),
        .done    (iter_done),
        .run_div (iter_div),
        .product (iter_product),
        .rem     (iter_rem),
        .quo     (iter_quo),
        .state   (iter_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_op  <= OP_NOOP;
            reg_a    <= '0;
            reg_b    <= '0;
            result   <= '0;
            disp_val <= '0;
            disp_sel <= SEL_NONE;
            done     <= 1'b0;
            neg      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            prev_op <= op_code;
            done    <= 1'b0;
            if (clear) begin
                reg_a    <= '0;
                reg_b    <= '0;
                result   <= '0;
                disp_val <= '0;
                disp_sel <= SEL_NONE;
                neg      <= 1'b0;
                div_zero <= 1'b0;
            end else begin
                case (op_code)
                    OP_DISP_A: begin
                        if (entry) reg_a <= data_in;
                        disp_val <= {{N{1'b0}}, (entry ? data_in : reg_a)};
                        disp_sel <= SEL_A;
                    end
                    OP_DISP_B: begin
                        if (entry) reg_b <= data_in;
                        disp_val <= {{N{1'b0}}, (entry ? data_in : reg_b)};
                        disp_sel <= SEL_B;
                    end
                    OP_DISP_RES: begin
                        disp_val <= result;
                        disp_sel <= SEL_RES;
                    end
                    default: ;
                endcase

                if (compute_entry) begin
                    case (compute_op)
                        CALC_ADD: begin
                            result   <= {{N{1'b0}}, reg_a} + {{N{1'b0}}, reg_b};
                            neg      <= 1'b0;
                            div_zero <= 1'b0;
                            done     <= 1'b1;
                        end
                        CALC_SUB: begin
                            result   <= {{N{1'b0}}, abs_diff};
                            neg      <= (reg_a < reg_b);
                            div_zero <= 1'b0;
                            done     <= 1'b1;
                        end
                        CALC_MUL: begin
                            neg      <= 1'b0;
                            div_zero <= 1'b0;
                        end
                        default: begin
                            neg <= 1'b0;
                            if (reg_b == '0) begin
                                result   <= {2*N{1'b1}};
                                div_zero <= 1'b1;
                                done     <= 1'b1;
                            end
                        end
                    endcase
                end

                if (iter_done) begin
                    result <= iter_div ? {iter_rem, iter_quo} : iter_product;
                    done   <= 1'b1;
                    if (iter_div) div_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_datapath.sv
// Directed bench for calc_datapath: a cycle-level behavioural model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_calc_datapath;

    localparam int N = 4;
    localparam int W = 2 * N;

    localparam logic [2:0] NOOP = 3'b000, DA = 3'b010, DB = 3'b100, COMP = 3'b101,
                           DRES = 3'b110, CLR = 3'b111;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   op_code;
    logic         wrt_addr;
    logic [1:0]   compute_op;
    logic [N-1:0] data_in;
    logic [W-1:0] disp_val;
    logic [1:0]   disp_sel;
    logic         busy;
    logic         done;
    logic         neg;
    logic         div_zero;

    int compared = 0;
    int failed   = 0;
    bit chk_en   = 1'b0;

    calc_datapath #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_code    (op_code),
        .wrt_addr   (wrt_addr),
        .compute_op (compute_op),
        .data_in    (data_in),
        .disp_val   (disp_val),
        .disp_sel   (disp_sel),
        .busy       (busy),
        .done       (done),
        .neg        (neg),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what each command should leave behind, with a countdown for iterative ops.
    logic [2:0]   m_prev;
    logic [W-1:0] m_a, m_b, m_res, m_disp, m_pend;
    logic [1:0]   m_sel;
    int           m_left;
    bit           m_neg, m_dz, m_done, m_pdiv;

    always @(posedge clk) begin : model
        bit entry;
        if (reset) begin
            m_prev = NOOP; m_a = '0; m_b = '0; m_res = '0; m_disp = '0; m_pend = '0;
            m_sel = 2'b00; m_left = 0; m_neg = 0; m_dz = 0; m_done = 0; m_pdiv = 0;
        end else begin
            entry  = (op_code != m_prev);
            m_prev = op_code;
            m_done = 0;
            if (op_code == CLR) begin
                m_a = '0; m_b = '0; m_res = '0; m_disp = '0; m_sel = 2'b00;
                m_neg = 0; m_dz = 0; m_left = 0;
            end else begin
                case (op_code)
                    DA:   begin if (entry) m_a = {4'b0, data_in}; m_disp = m_a; m_sel = 2'b01; end
                    DB:   begin if (entry) m_b = {4'b0, data_in}; m_disp = m_b; m_sel = 2'b10; end
                    DRES: begin m_disp = m_res; m_sel = 2'b11; end
                    default: ;
                endcase
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_res  = m_pend;
                        m_done = 1;
                        if (m_pdiv) m_dz = 0;
                    end
                end else if (entry && op_code == COMP) begin
                    case (compute_op)
                        ADD: begin m_res = m_a + m_b; m_neg = 0; m_dz = 0; m_done = 1; end
                        SUB: begin
                            m_res  = (m_a >= m_b) ? m_a - m_b : m_b - m_a;
                            m_neg  = (m_a < m_b);
                            m_dz   = 0;
                            m_done = 1;
                        end
                        MUL: begin m_pend = m_a * m_b; m_pdiv = 0; m_left = N; m_neg = 0; m_dz = 0; end
                        default: begin
                            m_neg = 0;
                            if (m_b == 0) begin
                                m_res = 8'hFF; m_dz = 1; m_done = 1;
                            end else begin
                                m_pend = ((m_a % m_b) << N) | (m_a / m_b);
                                m_pdiv = 1;
                                m_left = N;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("disp_val", disp_val, m_disp);
            check("disp_sel", W'(disp_sel), W'(m_sel));
            check("busy", W'(busy), W'(m_left > 0));
            check("done", W'(done), W'(m_done));
            check("neg", W'(neg), W'(m_neg));
            check("div_zero", W'(div_zero), W'(m_dz));
        end
    end

    task automatic drive(input logic [2:0] op, input logic [1:0] cop, input logic [N-1:0] din);
        op_code    = op;
        compute_op = cop;
        data_in    = din;
        wrt_addr   = (op == DB);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive(NOOP, ADD, 4'd0);
        @(negedge clk);
        chk_en = 1'b1;
        tick();
        check("reset_disp_val", disp_val, 8'h00);
        check("reset_disp_sel", W'(disp_sel), 8'h00);
        reset = 1'b0;
        tick();

        // 9 + 3
        drive(DA, ADD, 4'd9); tick();
        check("preview_a_val", disp_val, 8'h09);
        check("preview_a_sel", W'(disp_sel), 8'h01);
        drive(DB, ADD, 4'd3); tick();
        drive(COMP, ADD, 4'd0); tick();
        check("add_done_t1", W'(done), 8'h01);
        drive(DRES, ADD, 4'd0); tick();
        check("add_result", disp_val, 8'h0C);
        check("add_sel", W'(disp_sel), 8'h03);

        // |3 - 9| and |9 - 3|
        drive(DA, SUB, 4'd3); tick();
        drive(DB, SUB, 4'd9); tick();
        drive(COMP, SUB, 4'd0); tick();
        check("sub_neg_set", W'(neg), 8'h01);
        drive(DRES, SUB, 4'd0); tick();
        check("sub_result_neg", disp_val, 8'h06);
        drive(DA, SUB, 4'd9); tick();
        drive(DB, SUB, 4'd3); tick();
        drive(COMP, SUB, 4'd0); tick();
        check("sub_neg_clear", W'(neg), 8'h00);
        drive(DRES, SUB, 4'd0); tick();
        check("sub_result_pos", disp_val, 8'h06);

        // 15 x 15
        drive(DA, MUL, 4'd15); tick();
        drive(DB, MUL, 4'd15); tick();
        drive(COMP, MUL, 4'd0); tick();
        check("mul_busy_t1", W'(busy), 8'h01);
        tick(3);
        check("mul_busy_t4", W'(busy), 8'h01);
        check("mul_no_done_t4", W'(done), 8'h00);
        tick();
        check("mul_done_t5", W'(done), 8'h01);
        check("mul_idle_t5", W'(busy), 8'h00);
        drive(DRES, MUL, 4'd0); tick();
        check("mul_result", disp_val, 8'hE1);

        // 13 / 4, then divide by zero
        drive(DA, DIV, 4'd13); tick();
        drive(DB, DIV, 4'd4); tick();
        drive(COMP, DIV, 4'd0); tick(5);
        check("div_done_t5", W'(done), 8'h01);
        drive(DRES, DIV, 4'd0); tick();
        check("div_result", disp_val, 8'h13);
        check("div_zero_clear", W'(div_zero), 8'h00);
        drive(DB, DIV, 4'd0); tick();
        drive(COMP, DIV, 4'd0); tick();
        check("div0_done_t1", W'(done), 8'h01);
        check("div0_not_busy", W'(busy), 8'h00);
        check("div0_flag", W'(div_zero), 8'h01);
        drive(DRES, DIV, 4'd0); tick();
        check("div0_result", disp_val, 8'hFF);

        // Re-entering COMPUTE mid-run must not restart the multiply
        drive(DA, MUL, 4'd5); tick();
        drive(DB, MUL, 4'd3); tick();
        drive(COMP, MUL, 4'd0); tick();
        drive(NOOP, MUL, 4'd0); tick();
        drive(COMP, MUL, 4'd0); tick(3);
        check("reentry_done_t5", W'(done), 8'h01);
        drive(DRES, MUL, 4'd0); tick();
        check("reentry_result", disp_val, 8'h0F);

        // CLEAR aborts a running multiply
        drive(DA, MUL, 4'd15); tick();
        drive(DB, MUL, 4'd15); tick();
        drive(COMP, MUL, 4'd0); tick(2);
        drive(CLR, MUL, 4'd0); tick();
        check("clear_busy", W'(busy), 8'h00);
        check("clear_done", W'(done), 8'h00);
        check("clear_disp", disp_val, 8'h00);
        drive(NOOP, MUL, 4'd0); tick(3);
        drive(DRES, MUL, 4'd0); tick();
        check("clear_result", disp_val, 8'h00);

        // reset aborts a running multiply the same way
        drive(DA, MUL, 4'd15); tick();
        drive(DB, MUL, 4'd15); tick();
        drive(COMP, MUL, 4'd0); tick(2);
        reset = 1'b1; tick();
        reset = 1'b0;
        drive(NOOP, MUL, 4'd0);
        check("reset_abort_busy", W'(busy), 8'h00);
        check("reset_abort_done", W'(done), 8'h00);
        check("reset_abort_disp", disp_val, 8'h00);
        tick(3);
        drive(DRES, MUL, 4'd0); tick();
        check("reset_abort_result", disp_val, 8'h00);

        // Holding DISPLAY_A does not recapture
        drive(DA, ADD, 4'd2); tick();
        for (int i = 0; i < 4; i++) begin
            data_in = N'(4 + i);
            tick();
        end
        data_in = 4'd7; tick();
        check("hold_a_val", disp_val, 8'h02);
        drive(NOOP, ADD, 4'd7); tick();
        check("noop_hold_val", disp_val, 8'h02);
        check("noop_hold_sel", W'(disp_sel), 8'h01);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
